// File: rtl/arith_pkg.sv
// Shared arithmetic-family definitions: FSM state encoding and default operand width.
// Used by the serial subtractor and the ripple adder blocks.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from two half subtractors and an OR.
// It is the structural mirror of full_adder and serves as the serial cell.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_subtractor u_hs0 (
    .a    (a),
    .b    (b),
    .d    (w_d1),
    .bout (w_b1)
  );

  // The second stage borrows only when a==b and a borrow arrives.
  half_subtractor u_hs1 (
    .a    (w_d1),
    .b    (bin),
    .d    (d),
    .bout (w_b2)
  );

  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // DONE accepts a new start too, giving back-to-back operation.
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_br     <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bo;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 (directed + exhaustive)
// and WIDTH=8 (random vectors); a monitor pops expectations on every done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [3:0] d; logic bo; int cyc; } exp4_t;
  typedef struct { logic [7:0] d; logic bo; int cyc; } exp8_t;
  exp4_t q4[$];
  exp8_t q8[$];

  always @(negedge clk) begin
    exp4_t e;
    if (rst_n && done4) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done4 cyc=%0d diff=%h borrow=%b required no done", cyc, diff4, borrow4);
      end else begin
        e = q4.pop_front();
        if (diff4 !== e.d || borrow4 !== e.bo || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL result4 got diff=%h borrow=%b cyc=%0d required diff=%h borrow=%b cyc=%0d",
                   diff4, borrow4, cyc, e.d, e.bo, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp8_t e;
    if (rst_n && done8) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done8 cyc=%0d diff=%h borrow=%b required no done", cyc, diff8, borrow8);
      end else begin
        e = q8.pop_front();
        if (diff8 !== e.d || borrow8 !== e.bo || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL result8 got diff=%h borrow=%b cyc=%0d required diff=%h borrow=%b cyc=%0d",
                   diff8, borrow8, cyc, e.d, e.bo, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; the next edge accepts the start.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        input logic [3:0] ed, input logic ebo);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    q4.push_back('{ed, ebo, cyc + 1 + 4});
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait4();
    for (int i = 0; i < 40 && q4.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (q4.size() != 0) begin
      n_bad++;
      $display("FAIL timeout4 pending=%0d required 0", q4.size());
      q4.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait8();
    for (int i = 0; i < 60 && q8.size() != 0; i++) @(posedge clk);
    n_cmp++;
    if (q8.size() != 0) begin
      n_bad++;
      $display("FAIL timeout8 pending=%0d required 0", q8.size());
      q8.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] m4;
    logic [8:0] m8;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   32'(busy4),   32'd0);
    chk("reset_done",   32'(done4),   32'd0);
    chk("reset_diff",   32'(diff4),   32'd0);
    chk("reset_borrow", 32'(borrow4), 32'd0);
    chk("reset_busy8",  32'(busy8),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtract, with busy profile over the four shift cycles
    issue4(4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("busy_shift", 32'(busy4), 32'd1);
      @(posedge clk); #1;
    end
    chk("busy_at_done", 32'(busy4), 32'd0);
    chk("done_pulse",   32'(done4), 32'd1);
    wait4();
    chk("done_cleared", 32'(done4), 32'd0);

    // Underflow cases
    issue4(4'b0011, 4'b0110, 1'b0, 4'b1101, 1'b1);
    wait4();
    issue4(4'd0, 4'd0, 1'b1, 4'b1111, 1'b1);
    wait4();

    // Start pulsed while busy is ignored
    issue4(4'd9, 4'd2, 1'b0, 4'b0111, 1'b0);
    @(posedge clk); #1;
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait4();
    repeat (8) @(posedge clk);
    #1;
    chk("diff_held", 32'(diff4), 32'd7);

    // Back-to-back: start held through DONE
    a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back('{4'b0111, 1'b0, cyc + 1 + 4});
    @(posedge clk); #1;
    a4 = 4'd15; b4 = 4'd15;
    q4.push_back('{4'b0000, 1'b0, cyc + 5 + 4});
    repeat (5) @(posedge clk);
    #1;
    start4 = 1'b0;
    wait4();

    // Reset two cycles into an operation discards it
    issue4(4'd5, 4'd1, 1'b0, 4'd4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   32'(busy4),   32'd0);
    chk("midrst_done",   32'(done4),   32'd0);
    chk("midrst_diff",   32'(diff4),   32'd0);
    chk("midrst_borrow", 32'(borrow4), 32'd0);
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy4), 32'd0);

    fork
      begin
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            for (int bi = 0; bi < 2; bi++) begin
              m4 = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(bi);
              issue4(4'(a), 4'(b), 1'(bi), m4[3:0], m4[4]);
              wait4();
            end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
          m8 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
          start8 = 1'b1;
          q8.push_back('{m8[7:0], m8[8], cyc + 1 + 8});
          @(posedge clk); #1;
          start8 = 1'b0;
          wait8();
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
